// File: rtl/sfetch.sv
`timescale 1ns/1ps
// Instruction prefetch: credit-limited memory requests, in-order response
// buffer to the decoder, and discard of stale responses after a redirect.
//
// state | meaning
// RUN   | no stale responses pending; every response is buffered
// FLUSH | responses issued before the latest redirect are being discarded
module sfetch #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [DATA_WIDTH-1:0] RESET_PC_A = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

    typedef enum logic [0:0] {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_resp_pc;
    logic [OW-1:0]         r_outstanding;
    logic [OW-1:0]         r_discard;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];

    logic                  w_credit;
    logic                  w_issue;
    logic                  w_resp;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_target;
    logic [OW-1:0]         w_outstanding_nxt;
    logic [OW-1:0]         w_discard_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_unused;

    // r_live holds requests off until the first edge after reset release
    assign w_credit = r_live
                   && (r_outstanding < OW'(MAX_OUTSTANDING))
                   && ((SW'(r_outstanding) + SW'(r_count)) < SW'(FIFO_DEPTH));

    assign imem_req_o  = w_credit && !redirect_i;
    assign imem_addr_o = r_fetch_pc;
    assign w_issue     = imem_req_o && imem_gnt_i;
    assign w_resp      = imem_rvalid_i && (r_outstanding != '0);
    assign w_pop       = instr_valid_o && instr_ready_i;
    assign w_target    = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign w_unused    = ^redirect_pc_i[1:0];

    assign instr_valid_o = (r_count != '0) && !redirect_i;
    assign instr_o       = r_mem_instr[r_rd_ptr];
    assign pc_o          = r_mem_pc[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = (w_discard_nxt != '0) ? S_FLUSH : S_RUN;
    end

    always_comb begin
        w_push = 1'b0;
        w_drop = 1'b0;
        if (w_resp) begin
            if (redirect_i || (r_state == S_FLUSH)) begin
                w_drop = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    // a redirect re-arms the discard count with every response still owed
    always_comb begin
        w_outstanding_nxt = r_outstanding + OW'(w_issue) - OW'(w_resp);
        w_discard_nxt     = r_discard;
        if (redirect_i) begin
            w_discard_nxt = r_outstanding + OW'(w_issue) - OW'(w_resp);
        end else if (w_drop) begin
            w_discard_nxt = r_discard - OW'(1);
        end
        w_count_nxt = redirect_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live        <= 1'b0;
            r_fetch_pc    <= RESET_PC_A;
            r_resp_pc     <= RESET_PC_A;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_live        <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            if (redirect_i) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
                if (w_push)  r_resp_pc  <= r_resp_pc + DATA_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (redirect_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= imem_rdata_i;
                r_mem_pc[r_wr_ptr]    <= r_resp_pc;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid_i && (r_outstanding == '0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sfetch.sv
`timescale 1ns/1ps
// Bench for sfetch: random-stall memory model, queue scoreboard fed by the
// architectural PC stream, and directed startup/backpressure/redirect/reset cases.
module tb_sfetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int gnt_pct = 100;
    int rv_pct = 100;
    int resp_cnt = 0;
    int acc_cnt = 0;
    int resp_mark = 0;
    int acc_mark = 0;

    logic [31:0] mq[$];
    logic [63:0] exp_q[$];
    logic [31:0] gen_pc = RST_PC;

    sfetch #(
        .DATA_WIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    // low memory holds NOPs; everything else returns an address-derived word
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a < 32'h40) return 32'h0000_0013;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    // memory: in-order responses, random grant and response stalls
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
            end else begin
                imem_gnt_i = ($urandom_range(99) < gnt_pct);
                if (mq.size() > 0 && $urandom_range(99) < rv_pct) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_data(mq[0]);
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i  = $urandom;
                end
            end
            #2;
            if (rst_n) begin
                if (imem_rvalid_i) begin
                    void'(mq.pop_front());
                    resp_cnt++;
                end
                if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
            end
        end
    end

    // monitor: reset/redirect seed the expected stream, accepts pop and compare
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                gen_pc = RST_PC;
            end else begin
                if (redirect_i) chk("valid_during_redirect", instr_valid_o, 1'b0);
                if (instr_valid_o && instr_ready_i) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_empty: got pc %h expected no instruction", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", pc_o, e[63:32]);
                        chk("sb_instr", instr_o, e[31:0]);
                    end
                end
                if (redirect_i) begin
                    exp_q.delete();
                    gen_pc = {redirect_pc_i[31:2], 2'b00};
                end
                while (exp_q.size() < 8) begin
                    exp_q.push_back({gen_pc, mem_data(gen_pc)});
                    gen_pc = gen_pc + 32'd4;
                end
            end
        end
    end

    // returns one sample after the first post-reset edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        tick(3);
        rst_n = 1'b1;
        resp_mark = resp_cnt;
        acc_mark  = acc_cnt;
        sample();
        chk("req_before_first_edge", imem_req_o, 1'b0);
        sample();
        chk("first_req", imem_req_o, 1'b1);
        chk("first_addr", imem_addr_o, RST_PC);
    endtask

    task automatic first_pc_after(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            sample();
            if (instr_valid_o && instr_ready_i) begin
                found = 1;
                chk(name, pc_o, exp_pc);
                chk({name, "_instr"}, instr_o, mem_data(exp_pc));
            end
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no instruction within 60 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int cyc;
        #2;
        gnt_pct = 100;
        rv_pct  = 100;
        instr_ready_i = 1'b1;
        do_reset();

        // zero-wait startup: NOPs at 0, 4, 8 on consecutive cycles
        sample();
        sample();
        chk("start_valid0", instr_valid_o, 1'b1);
        chk("start_pc0", pc_o, 32'h0);
        chk("start_instr0", instr_o, 32'h13);
        sample();
        chk("start_valid1", instr_valid_o, 1'b1);
        chk("start_pc1", pc_o, 32'h4);
        sample();
        chk("start_valid2", instr_valid_o, 1'b1);
        chk("start_pc2", pc_o, 32'h8);

        // backpressure fills the buffer and stops requests
        tick(1);
        instr_ready_i = 1'b0;
        tick(10);
        sample();
        chk("bp_req", imem_req_o, 1'b0);
        chk("bp_outstanding", mq.size(), 32'd0);
        chk("bp_fill", (resp_cnt - resp_mark) - (acc_cnt - acc_mark), 32'd4);
        chk("bp_valid", instr_valid_o, 1'b1);
        tick(1);
        instr_ready_i = 1'b1;
        tick(20);

        // redirect with two responses owed
        rv_pct = 0;
        tick(6);
        sample();
        chk("rd_outstanding", mq.size(), 32'd2);
        tick(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick(1);
        redirect_i = 1'b0;
        rv_pct     = 100;
        first_pc_after("rd_first_pc", 32'h0000_0100);
        tick(10);

        // redirect coinciding with grant and response
        tick(5);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        sample();
        chk("rd_gnt_rv_req", imem_req_o, 1'b0);
        tick(1);
        redirect_i = 1'b0;
        first_pc_after("rd_gnt_rv_pc", 32'h0000_0300);
        tick(10);

        // address wrap
        gnt_pct = 70;
        rv_pct  = 70;
        tick(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF9;
        tick(1);
        redirect_i = 1'b0;
        first_pc_after("wrap_pc", 32'hFFFF_FFF8);
        tick(30);

        // reset with a full buffer
        gnt_pct = 100;
        rv_pct  = 100;
        instr_ready_i = 1'b0;
        tick(12);
        sample();
        chk("full_before_reset", instr_valid_o, 1'b1);
        tick(1);
        do_reset();
        tick(1);
        instr_ready_i = 1'b1;
        first_pc_after("restart_pc", RST_PC);

        // randomized stalls, backpressure and redirects
        gnt_pct = 70;
        rv_pct  = 65;
        start   = acc_cnt;
        cyc     = 0;
        while ((acc_cnt - start) < 10000 && cyc < 60000) begin
            tick(1);
            cyc++;
            instr_ready_i = ($urandom_range(99) < 75);
            redirect_i = ($urandom_range(199) == 0) || (redirect_i && $urandom_range(3) == 0);
            if (redirect_i) begin
                if ($urandom_range(3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | $urandom_range(15);
                else                        redirect_pc_i = $urandom;
            end
        end
        redirect_i = 1'b0;
        chk("rand_progress", ((acc_cnt - start) >= 10000) ? 32'd1 : 32'd0, 32'd1);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
